// File: rtl/full_adder.sv
// full_adder: ripple-carry adder built from 1-bit full adder cells.
// Optional output register stage with async active-low reset.
module full_adder #(
  parameter int unsigned WIDTH        = 1,
  parameter bit          REGISTER_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign p[i]   = A[i] ^ B[i];
    assign g[i]   = A[i] & B[i];
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = g[i] | (c[i] & p[i]);
  end

  // Collect the ripple result; ovf compares carry into and out of the MSB.
  always_comb begin
    sum_d  = s;
    cout_d = c[WIDTH];
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
  end

  if (REGISTER_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Capture the combinational result each edge; reset clears all.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum  = sum_d;
    assign cout = cout_d;
    assign ovf  = ovf_d;
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks of full_adder
// in 1/8/16-bit, combinational and registered configurations.
module tb_full_adder;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_err;

  // 1-bit comb, clk/rst_n connected
  logic a1, b1, ci1, s1, co1, ov1;
  // 1-bit comb, clk/rst_n tied off
  logic s1t, co1t, ov1t;
  // 8-bit comb
  logic [7:0] a8, b8, s8;
  logic       ci8, co8, ov8;
  // 8-bit registered
  logic [7:0] a8r, b8r, s8r;
  logic       ci8r, co8r, ov8r;
  // 16-bit comb
  logic [15:0] a16, b16, s16;
  logic        ci16, co16, ov16;

  full_adder #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_fa1 (
    .clk(clk), .rst_n(rst_n),
    .A(a1), .B(b1), .cin(ci1),
    .sum(s1), .cout(co1), .ovf(ov1)
  );

  full_adder #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_fa1t (
    .clk(1'b0), .rst_n(1'b1),
    .A(a1), .B(b1), .cin(ci1),
    .sum(s1t), .cout(co1t), .ovf(ov1t)
  );

  full_adder #(.WIDTH(8), .REGISTER_OUT(1'b0)) u_fa8 (
    .clk(clk), .rst_n(rst_n),
    .A(a8), .B(b8), .cin(ci8),
    .sum(s8), .cout(co8), .ovf(ov8)
  );

  full_adder #(.WIDTH(8), .REGISTER_OUT(1'b1)) u_fa8r (
    .clk(clk), .rst_n(rst_n),
    .A(a8r), .B(b8r), .cin(ci8r),
    .sum(s8r), .cout(co8r), .ovf(ov8r)
  );

  full_adder #(.WIDTH(16), .REGISTER_OUT(1'b0)) u_fa16 (
    .clk(clk), .rst_n(rst_n),
    .A(a16), .B(b16), .cin(ci16),
    .sum(s16), .cout(co16), .ovf(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 1-bit truth table, expected {sum,cout} indexed by {A,B,cin}
  logic [1:0] tt [8];

  // registered-stage vectors: A, B, cin, sum, cout, ovf
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec8_t;

  vec8_t rv [5];

  initial begin
    logic [16:0] ref17;
    logic        ref_ov;
    logic [2:0]  idx;
    logic [7:0]  prev_s;
    logic        prev_co;
    logic        prev_ov;

    n_chk = 0;
    n_err = 0;

    tt[0] = 2'b00; tt[1] = 2'b10;
    tt[2] = 2'b10; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b01;
    tt[6] = 2'b01; tt[7] = 2'b11;

    rv[0] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    rv[1] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    rv[2] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0};
    rv[3] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    rv[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst_n = 1'b1;
    a1 = 0; b1 = 0; ci1 = 0;
    a8 = 0; b8 = 0; ci8 = 0;
    a8r = 0; b8r = 0; ci8r = 0;
    a16 = 0; b16 = 0; ci16 = 0;

    // reset asserted before the first clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sum", 64'(s8r), 64'h0);
    chk("rst_cout", 64'(co8r), 64'h0);
    chk("rst_ovf", 64'(ov8r), 64'h0);

    // 1-bit truth table, both tie-off styles
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      a1 = idx[2]; b1 = idx[1]; ci1 = idx[0];
      #4;
      chk($sformatf("tt1_%0d", i), 64'({s1, co1}), 64'(tt[i]));
      chk($sformatf("tt1t_%0d", i), 64'({s1t, co1t}), 64'(tt[i]));
      #1;
    end

    // 8-bit combinational boundaries
    a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; #1;
    chk("c8_ripple", 64'({co8, ov8, s8}), 64'({1'b1, 1'b0, 8'h00}));
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; #1;
    chk("c8_posovf", 64'({co8, ov8, s8}), 64'({1'b0, 1'b1, 8'h80}));
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; #1;
    chk("c8_negovf", 64'({co8, ov8, s8}), 64'({1'b1, 1'b1, 8'h00}));
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; #1;
    chk("c8_allones", 64'({co8, ov8, s8}), 64'({1'b1, 1'b0, 8'hFF}));
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0; #1;
    chk("c8_zero", 64'({co8, ov8, s8}), 64'({1'b0, 1'b0, 8'h00}));

    // registered: edges ignored while reset held
    a8r = 8'hAA; b8r = 8'h11; ci8r = 1'b1;
    @(posedge clk); #1;
    chk("r8_rst_hold", 64'({co8r, ov8r, s8r}), 64'h0);

    // release between edges; first result one edge later
    @(negedge clk);
    rst_n = 1'b1;
    a8r = rv[0].a; b8r = rv[0].b; ci8r = rv[0].ci;
    #1;
    chk("r8_pre_edge", 64'({co8r, ov8r, s8r}), 64'h0);
    @(posedge clk); #1;
    chk("r8_first", 64'({co8r, ov8r, s8r}),
        64'({rv[0].co, rv[0].ov, rv[0].s}));
    prev_s = rv[0].s; prev_co = rv[0].co; prev_ov = rv[0].ov;

    // back-to-back operands; old result held until the next edge
    for (int i = 1; i < 5; i++) begin
      a8r = rv[i].a; b8r = rv[i].b; ci8r = rv[i].ci;
      #1;
      chk($sformatf("r8_hold_%0d", i), 64'({co8r, ov8r, s8r}),
          64'({prev_co, prev_ov, prev_s}));
      @(posedge clk); #1;
      chk($sformatf("r8_b2b_%0d", i), 64'({co8r, ov8r, s8r}),
          64'({rv[i].co, rv[i].ov, rv[i].s}));
      prev_s = rv[i].s; prev_co = rv[i].co; prev_ov = rv[i].ov;
    end

    // async reset mid-cycle while sum=0xFF
    #2 rst_n = 1'b0;
    #1;
    chk("r8_async_rst", 64'({co8r, ov8r, s8r}), 64'h0);
    @(posedge clk); #1;
    chk("r8_rst_edge", 64'({co8r, ov8r, s8r}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a8r = 8'h7F; b8r = 8'h01; ci8r = 1'b0;
    @(posedge clk); #1;
    chk("r8_after_rst", 64'({co8r, ov8r, s8r}),
        64'({1'b0, 1'b1, 8'h80}));

    // 16-bit random against an arithmetic reference
    for (int i = 0; i < 10000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      ci16 = 1'($urandom);
      #1;
      ref17 = {1'b0, a16} + {1'b0, b16} + {16'b0, ci16};
      ref_ov = (a16[15] == b16[15]) && (ref17[15] != a16[15]);
      chk("r16_sum", 64'({co16, s16}), 64'(ref17));
      chk("r16_ovf", 64'(ov16), 64'(ref_ov));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
